mem_access_unit: RTL

Load/store engine that consumes the latched ALU result as an effective address and performs one data-memory transaction per request in the multicycle CPU's MEM step. The control unit pulses `start`; the block drives a req/ack memory port, handles byte/half/word lanes, formats load data into a registered MDR value and pulses `done`. It sits between the ALU-result register, the B operand register, the control FSM and data memory.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_fmt.sv | 56 +++++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared definitions for the load/store engine of the multicycle CPU.
//   Contents:
//     SZ_BYTE / SZ_HALF / SZ_WORD : access size encodings (2'b11 is also a word)
//     state_t                     : mem_access_unit FSM states (IDLE, REQ, DONE)
//     isMisaligned()              : alignment check used when MEM_MISALIGN_TRAP_EN
//                                   is defined
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A half needs an even address, a word needs both low bits clear.
    // Any size with bit 1 set is treated as a word.
    function automatic logic isMisaligned(input logic [1:0] size,
                                          input logic [1:0] lowAddr);
        logic result;
        result = 1'b0;
        if (size[1])
            result = (lowAddr != 2'b00);
        else if (size == SZ_HALF)
            result = lowAddr[0];
        return result;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt
//   Purely combinational lane logic for little-endian byte/half/word accesses.
//   Ports:
//     size     in  2  access size (SZ_BYTE, SZ_HALF, word otherwise)
//     lowAddr  in  2  low two address bits selecting the lane(s)
//     signExt  in  1  sign-extend byte/half loads
//     wdata    in  32 raw store data
//     memRdata in  32 raw word read from memory
//     be       out 4  byte enables
//     wdataRep out 32 store data replicated across lanes
//     loadData out 32 extracted and extended load result
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lowAddr,
    input  logic        signExt,
    input  logic [31:0] wdata,
    input  logic [31:0] memRdata,
    output logic [3:0]  be,
    output logic [31:0] wdataRep,
    output logic [31:0] loadData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Lane selection; half accesses look only at addr[1], so an odd half
    // address silently uses the enclosing aligned half.
    always_comb begin
        byteVal = 8'h00;
        case (lowAddr)
            2'd0:    byteVal = memRdata[7:0];
            2'd1:    byteVal = memRdata[15:8];
            2'd2:    byteVal = memRdata[23:16];
            default: byteVal = memRdata[31:24];
        endcase
        halfVal = lowAddr[1] ? memRdata[31:16] : memRdata[15:0];
    end

    always_comb begin
        be       = 4'b1111;
        wdataRep = wdata;
        loadData = memRdata;
        if (size == SZ_BYTE) begin
            be       = 4'b0001 << lowAddr;
            wdataRep = {4{wdata[7:0]}};
            loadData = {{24{signExt & byteVal[7]}}, byteVal};
        end else if (size == SZ_HALF) begin
            be       = lowAddr[1] ? 4'b1100 : 4'b0011;
            wdataRep = {2{wdata[15:0]}};
            loadData = {{16{signExt & halfVal[15]}}, halfVal};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-step load/store engine: one req/ack data-memory transaction per start
//   pulse, with lane handling, registered load result and a timeout abort.
//   Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses
//   finish immediately with err and never touch the bus).
//   Ports:
//     CLK, RST_n           clock, asynchronous active-low reset
//     start                request pulse (sampled only in IDLE)
//     memWrite, size,      store/load, access size, sign extension,
//     signExt, addr, wdata effective address, store data
//     busy, done, err      status; err is valid with done
//     rdata                formatted load result, held until next good load
//     mem_req .. mem_wdata registered memory request, zero outside REQ
//     mem_rdata, mem_ack   memory response
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start,
    input  logic        memWrite,
    input  logic [1:0]  size,
    input  logic        signExt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, stateNext;
    logic [CW-1:0]   count;
    logic [CW-1:0]   countInc;
    logic            timeoutHit;
    logic            misaligned;
    logic            weQ, signExtQ;
    logic [1:0]      sizeQ, lowQ;
    logic [1:0]      fmtSize, fmtLow;
    logic            fmtSignExt;
    logic [3:0]      fmtBe;
    logic [31:0]     fmtWdata, fmtLoad;

    // The single formatter sees the live inputs while IDLE (to build the bus
    // request) and the captured request afterwards (to extract load data).
    assign fmtSize    = (state == IDLE) ? size       : sizeQ;
    assign fmtLow     = (state == IDLE) ? addr[1:0]  : lowQ;
    assign fmtSignExt = (state == IDLE) ? signExt    : signExtQ;

    mem_lane_fmt u_fmt (
        .size     (fmtSize),
        .lowAddr  (fmtLow),
        .signExt  (fmtSignExt),
        .wdata    (wdata),
        .memRdata (mem_rdata),
        .be       (fmtBe),
        .wdataRep (fmtWdata),
        .loadData (fmtLoad)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = isMisaligned(size, addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // The count reaching TIMEOUT on this edge ends the request; mem_req has
    // then been high for exactly TIMEOUT cycles.
    assign countInc   = count + 1'b1;
    assign timeoutHit = (countInc == CW'(TIMEOUT));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next-state logic; ack takes priority over a simultaneous timeout.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = misaligned ? DONE : REQ;
            REQ:     if (mem_ack || timeoutHit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request capture, bus registers, timeout counter and load result.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            count     <= '0;
            weQ       <= 1'b0;
            signExtQ  <= 1'b0;
            sizeQ     <= SZ_BYTE;
            lowQ      <= 2'b00;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    err   <= 1'b0;
                    if (start) begin
                        weQ      <= memWrite;
                        signExtQ <= signExt;
                        sizeQ    <= size;
                        lowQ     <= addr[1:0];
                        if (misaligned) begin
                            err <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= memWrite;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= fmtBe;
                            mem_wdata <= memWrite ? fmtWdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack || timeoutHit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        err       <= !mem_ack;
                        if (mem_ack && !weQ)
                            rdata <= fmtLoad;
                    end else begin
                        count <= countInc;
                    end
                end
                default: begin
                    err <= 1'b0;
                end
            endcase
        end
    end

endmodule
